fpu_uni2ieee: RTL
=================

# fpu_uni2ieee

Output-side converter for the FPALU result bus. It takes one unified-format result per handshake (sign, 6-bit biased exponent, 22-bit left-aligned denormal mantissa) and produces a normalized IEEE-754 binary32 word. It sits directly downstream of FPALU in a 2-stage valid/ready pipeline and supports full throughput and backpressure. The conversion is exact: every unified value maps to an IEEE normal number or zero, so no rounding is needed.

## Interface
Parameters: none. Widths are fixed by the unified format.

- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- din_uni_y_sgn  in  1  FPALU result sign
- din_uni_y_exp  in  6  FPALU result exponent, bias 32
- din_uni_y_man_dn  in  22  FPALU result mantissa; bit 21 has weight 1.0, not necessarily normalized
- in_valid  in  1  input word present
- in_ready  out  1  block accepts the input this cycle
- dout_ieee  out  32  IEEE-754 binary32 result
- dout_zero  out  1  result is ±0
- out_valid  out  1  dout_ieee/dout_zero valid
- out_ready  in  1  consumer accepts the output this cycle

## Operation
- Unified value = (-1)^sgn × man × 2^-21 × 2^(exp−32).
- Stage 1 (S1), on accept (in_valid && in_ready):
  - register sgn, exp and man;
  - register lz = leading-zero count of man (0..21), computed combinationally from the input;
  - register zero = (man == 0).
- Stage 2 (S2), when S1 advances, registers the packed word:
  - zero: dout_ieee = {sgn, 31'b0}, dout_zero = 1. A nonzero exp is ignored; sign is preserved.
  - otherwise: m = man << lz, so m[21] = 1.
  - IEEE exp = exp + 95 − lz. Compute it in at least 8 bits. The range is 74..158, so it never overflows or underflows and never yields a subnormal or Inf.
  - fraction = {m[20:0], 2'b00}; dout_ieee = {sgn, exp8, frac23}, dout_zero = 0.
- No NaN or Inf is ever produced.
- FSM: none. The pipeline control is two valid flags, s1_v and s2_v (out_valid = s2_v).
  - s2_adv = !s2_v || out_ready
  - s1_adv = s1_v && s2_adv
  - in_ready = !s1_v || s2_adv (combinational from registered state and out_ready)
  - s1_v next = accept ? 1 : (s1_adv ? 0 : s1_v)
  - s2_v next = s1_adv ? 1 : (out_ready ? 0 : s2_v)

## Timing
- Reset, synchronous, for the cycle rst is sampled high: s1_v = 0, s2_v = 0, dout_ieee = 0, dout_zero = 0, all S1 data registers = 0.
- During and after reset: in_ready = 1 and out_valid = 0.
- Reset mid-operation discards both in-flight words; nothing reaches the output afterwards.
- Latency: a word accepted at edge N appears with out_valid = 1 after edge N+1, provided out_ready was high or S2 was empty.
- Throughput: one word per cycle while out_ready = 1.
- Stall (out_valid && !out_ready):
  - dout_ieee and dout_zero hold bit-stable;
  - S1 holds its word;
  - in_ready = 0 once S1 is also full.
- Simultaneous events:
  - S2 draining (out_ready = 1) and S1 advancing in the same cycle is legal; S2 reloads with no bubble.
  - Input accept and S1 advance in the same cycle is legal; S1 reloads.
- Input data is sampled only on accept. Inputs held while in_ready = 0 are not consumed twice.
- in_valid may drop without an accept; no state changes.

## Test plan
- sgn=0, exp=32, man=22'h200000 -> dout_ieee = 32'h3F800000, dout_zero = 0, out_valid exactly 2 edges after accept.
- Back-to-back with out_ready = 1:
  - (0, 32, 22'h100000) -> 32'h3F000000
  - (1, 33, 22'h300000) -> 32'hC0400000
  - (0, 0, 22'h000001) -> 32'h25000000
  - results arrive on consecutive cycles.
- Zero handling: (1, 45, 22'h0) -> 32'h80000000 with dout_zero = 1; (0, 7, 22'h0) -> 32'h00000000 with dout_zero = 1.
- Backpressure:
  - hold out_ready = 0 for 5 cycles while streaming 4 words -> in_ready falls after 2 accepts and dout_ieee stays stable;
  - release -> all 4 words emerge in order with no loss or duplication.
- Reset mid-stream: assert rst with both stages full -> the next edge gives out_valid = 0, in_ready = 1, dout_ieee = 0, and no stale word appears later.
- Random sweep of 10k words with random out_ready -> every output matches the reference model value(sgn, exp, man) and ordering is preserved.

Source files
------------

// File: rtl/fpu_uni2ieee_if.sv
// Result bus between FPALU (unified format) and the IEEE-754 binary32 packer.
// The master drives the unified word and out_ready; the slave returns the packed word.
interface fpu_uni2ieee_if;
    logic        din_uni_y_sgn;
    logic [5:0]  din_uni_y_exp;
    logic [21:0] din_uni_y_man_dn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dout_ieee;
    logic        dout_zero;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output din_uni_y_sgn, din_uni_y_exp, din_uni_y_man_dn, in_valid, out_ready,
        input  in_ready, dout_ieee, dout_zero, out_valid
    );

    modport slave (
        input  din_uni_y_sgn, din_uni_y_exp, din_uni_y_man_dn, in_valid, out_ready,
        output in_ready, dout_ieee, dout_zero, out_valid
    );
endinterface

// File: rtl/fpu_uni2ieee.sv
// Unified FPALU result -> normalized IEEE-754 binary32; 2-stage valid/ready pipe, 1 cycle
// from accept to out_valid, full throughput, S2 holds bit-stable and S1 fills under backpressure.
module fpu_uni2ieee (
    input  logic          clk,
    input  logic          rst,
    fpu_uni2ieee_if.slave bus
);

    logic        r_s1_v;
    logic        r_s2_v;
    logic        r_sgn;
    logic [5:0]  r_exp;
    logic [21:0] r_man;
    logic [4:0]  r_lz;
    logic        r_zero;
    logic [31:0] r_dout_ieee;
    logic        r_dout_zero;

    logic        w_s2_adv;
    logic        w_s1_adv;
    logic        w_in_ready;
    logic        w_accept;
    logic [4:0]  w_lz;
    logic [20:0] w_frac;
    logic [7:0]  w_exp8;

    assign w_s2_adv   = !r_s2_v || bus.out_ready;
    assign w_s1_adv   = r_s1_v && w_s2_adv;
    assign w_in_ready = !r_s1_v || w_s2_adv;
    assign w_accept   = bus.in_valid && w_in_ready;

    // Highest set bit wins; an all-zero mantissa leaves lz at 0 and is flagged separately.
    always_comb begin
        w_lz = 5'd0;
        for (int i = 0; i < 22; i++) begin
            if (bus.din_uni_y_man_dn[i]) begin
                w_lz = 5'(21 - i);
            end
        end
    end

    // Leading one is shifted out of the top; the remaining 21 bits are the fraction MSBs.
    assign w_frac = 21'(r_man << r_lz);
    assign w_exp8 = 8'(r_exp) + 8'd95 - 8'(r_lz);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v      <= 1'b0;
            r_s2_v      <= 1'b0;
            r_sgn       <= 1'b0;
            r_exp       <= 6'd0;
            r_man       <= 22'd0;
            r_lz        <= 5'd0;
            r_zero      <= 1'b0;
            r_dout_ieee <= 32'd0;
            r_dout_zero <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sgn  <= bus.din_uni_y_sgn;
                r_exp  <= bus.din_uni_y_exp;
                r_man  <= bus.din_uni_y_man_dn;
                r_lz   <= w_lz;
                r_zero <= (bus.din_uni_y_man_dn == 22'd0);
            end
            r_s1_v <= w_accept ? 1'b1 : (w_s1_adv ? 1'b0 : r_s1_v);
            r_s2_v <= w_s1_adv ? 1'b1 : (bus.out_ready ? 1'b0 : r_s2_v);
            if (w_s1_adv) begin
                if (r_zero) begin
                    r_dout_ieee <= {r_sgn, 31'd0};
                    r_dout_zero <= 1'b1;
                end else begin
                    r_dout_ieee <= {r_sgn, w_exp8, w_frac, 2'b00};
                    r_dout_zero <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_s2_v;
    assign bus.dout_ieee = r_dout_ieee;
    assign bus.dout_zero = r_dout_zero;

endmodule
